mbssoc_ram_ctrl: RTL and testbench
==================================

// Module: mbssoc_ram_ctrl
// PURPOSE
//  Memory controller directly upstream of the SoC word RAM. Arbitrates between the core's
//  instruction-fetch port and its load/store port, and sequences the RAM's shared tristate data bus.
//  RAM protocol:
//   - RAM registers addr on clk. Read data is valid in the cycle after addr, while ram_re=1.
//   - RAM writes at posedge when ram_we=1.
//  Sub-word stores (byte enables) are done as read-modify-write.
// PARAMETERS
//  ADDR_W     `ADDR_WIDTH      byte-address width
//  DATA_W     `DATA_WIDTH      word width; fixed at 32 (4 byte lanes)
//  MEM_WORDS  `MEM_LEN         RAM depth in words; used for range checking
// PORTS
//  clk        in   1        system clock; all state updates on posedge
//  rst_n      in   1        asynchronous, active-low reset
//  if_req     in   1        fetch request; held with if_addr until if_ack
//  if_addr    in   ADDR_W   fetch byte address
//  if_rdata   out  DATA_W   fetched word; valid while if_ack=1
//  if_ack     out  1        one-cycle completion pulse
//  d_req      in   1        load/store request; held with all d_* inputs until d_ack
//  d_we       in   1        1 = store, 0 = load
//  d_be       in   4        store byte enables; bit i = bits [8i+7:8i]
//  d_addr     in   ADDR_W   load/store byte address
//  d_wdata    in   DATA_W   store data, lane-aligned
//  d_rdata    out  DATA_W   loaded word; valid while d_ack=1
//  d_ack      out  1        one-cycle completion pulse
//  d_err      out  1        pulses with d_ack when the word index is out of range
//  ram_re     out  1        RAM read enable
//  ram_we     out  1        RAM write enable
//  ram_addr   out  ADDR_W   RAM byte address; low 2 bits always 0
//  ram_data   inout DATA_W  shared bus; driven only in S_WRITE, otherwise 'z
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State -> S_IDLE.
//   - All outputs 0; ram_data = 'z; rdata registers = 0.
//   - A write in flight is aborted: ram_we drops immediately.
//  Arbitration (S_IDLE only):
//   - d_req has fixed priority over if_req.
//   - The winner's addr/we/be/wdata are latched, plus a port-select bit.
//   - Inputs are ignored outside S_IDLE.
//  States:
//   - S_IDLE
//   - S_RADDR: ram_addr driven, ram_re=0
//   - S_RDATA: ram_re=1; sample ram_data at the end of the cycle
//   - S_WRITE: ram_we=1; ram_data driven
//   - S_ACK: selected port's ack=1 for exactly one cycle; then -> S_IDLE
//  Transitions from S_IDLE:
//   - Fetch, or load                 -> S_RADDR -> S_RDATA -> S_ACK
//   - Store with d_be = 4'b1111      -> S_WRITE -> S_ACK
//   - Store with partial d_be        -> S_RADDR -> S_RDATA (merge: enabled lanes from wdata,
//                                       others from RAM word) -> S_WRITE -> S_ACK
//   - Store with d_be = 0            -> S_ACK; no RAM access
//   - Word index (addr>>2) >= MEM_WORDS -> S_ACK with d_err=1 (or if_ack); rdata=0; no RAM access
//  Latency (req high in S_IDLE at cycle 0):
//   - Read: ack in cycle 3.
//   - Full store: ack in cycle 2.
//   - RMW store: ack in cycle 4.
//  ram_addr: {latched addr[ADDR_W-1:2], 2'b00} in S_RADDR, S_RDATA and S_WRITE; 0 otherwise.
//  Bus rules:
//   - ram_re and ram_we are never both 1.
//   - ram_data is driven only while ram_we=1, so there is no contention with the RAM's read driver.
//  Back-to-back:
//   - After S_ACK the controller returns to S_IDLE.
//   - A requester that keeps req high after its ack starts a new transaction.
//   - Fetch can starve under continuous d_req; accepted, because the core stalls on d_ack.
//  Unaligned addresses: low 2 bits are ignored for word selection; lane selection is by d_be only.
//  Outputs are registered or decoded purely from state; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared include (MBScore_const.v):
//   - State encodings `MC_S_IDLE/RADDR/RDATA/WRITE/ACK (3 bits).
//   - `BE_WIDTH = `DATA_WIDTH/8.
//  Sub-module mbssoc_be_merge (combinational): (old word, new word, be) -> merged word.
//   - Reusable by the cache path later.
//  Top level contains: FSM, request latch, rdata registers, tristate driver.
// TESTING
//  - Reset mid-S_WRITE (rst_n low for 1 cycle) -> ram_we=0 immediately, bus 'z, RAM word unchanged,
//    state S_IDLE.
//  - if_req, if_addr=0x10, RAM[4]=0xDEADBEEF -> if_ack in cycle 3, if_rdata=0xDEADBEEF, d_ack never set.
//  - d_req store, d_addr=0x20, be=1111, wdata=0x12345678 -> ram_we in cycle 1 only, d_ack in cycle 2;
//    a following load of 0x20 returns 0x12345678.
//  - RAM[8]=0xAABBCCDD; store be=0010, wdata=0x00005500 -> ack in cycle 4, RAM[8]=0xAABB55DD.
//  - if_req and d_req both high in the same cycle -> data served first, fetch ack follows its own
//    read latency; ram_re and ram_we never high together (assertion).
//  - d_addr = MEM_WORDS*4 -> d_ack with d_err=1 in cycle 1, d_rdata=0, ram_re=ram_we=0 throughout.

Source files
------------

// File: rtl/mbssoc_ram_ctrl_pkg.sv
// Shared types and constants for the SoC word-RAM controller and its helpers.
package mbssoc_ram_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
    localparam int unsigned MEM_LEN    = 1024;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_ACK   = 3'd4
    } mc_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } mc_port_e;

    // Control half of a latched request; address and data are kept alongside.
    typedef struct packed {
        mc_port_e              port;
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic                  err;
    } mc_req_t;

endpackage

// File: rtl/mbssoc_ram_ctrl_be_merge.sv
// Byte-lane merge: enabled lanes come from the new word, the rest from the old word.
module mbssoc_be_merge
    import mbssoc_ram_ctrl_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] merged_c
);

    always_comb begin
        merged_c = old_word;
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                merged_c[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mbssoc_ram_ctrl.sv
// Word-RAM controller: arbitrates fetch vs load/store and sequences the shared RAM data bus.
module mbssoc_ram_ctrl
    import mbssoc_ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_WIDTH,
    parameter int unsigned MEM_WORDS = MEM_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [BE_WIDTH-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    mc_state_e               state_q, state_d;
    mc_req_t                 req_q, req_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                    if_ack_q, if_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic                    d_err_q, d_err_d;
    logic                    ram_re_q, ram_re_d;
    logic                    ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   merged_c;
    logic                    unused_addr_lsb;

    // Byte offset bits never select a word; lanes come from d_be alone.
    assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

    mbssoc_be_merge u_merge (
        .old_word (ram_data),
        .new_word (wdata_q),
        .be       (req_q.be),
        .merged_c (merged_c)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (d_req || if_req) begin
                    req_d.port = d_req ? PORT_D : PORT_IF;
                    req_d.we   = d_req & d_we;
                    req_d.be   = d_req ? d_be : '0;
                    idx_d      = d_req ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
                    wdata_d    = d_req ? d_wdata : '0;
                    req_d.err  = (32'(idx_d) >= 32'(MEM_WORDS));
                    if (req_d.err) begin
                        state_d = S_ACK;
                        if (d_req) d_rdata_d  = '0;
                        else       if_rdata_d = '0;
                    end else if (req_d.we && (req_d.be == '0)) begin
                        state_d = S_ACK;
                    end else if (req_d.we && (&req_d.be)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RADDR;
                    end
                end
            end
            S_RADDR: state_d = S_RDATA;
            S_RDATA: begin
                if (req_q.we) begin
                    wdata_d = merged_c;
                    state_d = S_WRITE;
                end else begin
                    if (req_q.port == PORT_IF) if_rdata_d = ram_data;
                    else                       d_rdata_d  = ram_data;
                    state_d = S_ACK;
                end
            end
            S_WRITE: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered copies of the next-state decode.
        ram_re_d   = (state_d == S_RDATA);
        ram_we_d   = (state_d == S_WRITE);
        ram_addr_d = (state_d == S_RADDR || state_d == S_RDATA || state_d == S_WRITE)
                     ? {idx_d, 2'b00} : '0;
        if_ack_d   = (state_d == S_ACK) && (req_d.port == PORT_IF);
        d_ack_d    = (state_d == S_ACK) && (req_d.port == PORT_D);
        d_err_d    = d_ack_d && req_d.err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            ram_re_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
            ram_re_q   <= ram_re_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    // Bus is driven only while the write strobe is up, so it never fights the RAM.
    assign ram_data = ram_we_q ? wdata_q : 'z;

    assign if_rdata = if_rdata_q;
    assign if_ack   = if_ack_q;
    assign d_rdata  = d_rdata_q;
    assign d_ack    = d_ack_q;
    assign d_err    = d_err_q;
    assign ram_re   = ram_re_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_mbssoc_ram_ctrl.sv
// Bench for mbssoc_ram_ctrl: RAM model, word-array reference model, directed and random transactions.
module tb_mbssoc_ram_ctrl;
    import mbssoc_ram_ctrl_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned MW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata, if_rdata, d_rdata;
    logic          if_ack, d_ack, d_err, ram_re, ram_we;
    logic [AW-1:0] ram_addr;
    wire  [31:0]   ram_data;

    int checks = 0;
    int errors = 0;

    logic [31:0]   mem [MW];
    logic [31:0]   ref_mem [MW];
    logic [AW-1:0] ram_addr_reg;
    logic          bk_we;
    logic [5:0]    bk_idx;
    logic [31:0]   bk_data;

    mbssoc_ram_ctrl #(.ADDR_W(AW), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: registered address, read data in the following cycle while ram_re.
    always @(posedge clk) begin
        ram_addr_reg <= ram_addr;
        if (ram_we)     mem[ram_addr[7:2]] <= ram_data;
        else if (bk_we) mem[bk_idx] <= bk_data;
    end
    assign ram_data = ram_re ? mem[ram_addr_reg[7:2]] : 'z;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(ram_re && ram_we)) else begin
                errors++;
                $error("FAIL re_we_excl: observed re=%0b we=%0b expected not both", ram_re, ram_we);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic backdoor(input int unsigned idx, input logic [31:0] data);
        bk_idx = 6'(idx); bk_data = data; bk_we = 1'b1;
        ref_mem[idx] = data;
        @(posedge clk); #1;
        bk_we = 1'b0;
    endtask

    task automatic data_txn(input string tag, input logic we, input logic [3:0] be,
                            input logic [AW-1:0] addr, input logic [31:0] wdata);
        int unsigned idx;
        logic        err, err_seen, saw_if;
        int          exp_lat, exp_re, exp_we, exp_we_cyc, lat, re_n, we_n, we_cyc;
        logic [31:0] rd;
        idx = 32'(addr) >> 2;
        err = (idx >= MW);
        exp_re = 0; exp_we = 0; exp_we_cyc = 0;
        if (err)              exp_lat = 1;
        else if (!we)         begin exp_lat = 3; exp_re = 1; end
        else if (be == 4'h0)  exp_lat = 1;
        else if (be == 4'hF)  begin exp_lat = 2; exp_we = 1; exp_we_cyc = 1; end
        else                  begin exp_lat = 4; exp_re = 1; exp_we = 1; exp_we_cyc = 3; end
        lat = 0; re_n = 0; we_n = 0; we_cyc = 0; saw_if = 0; err_seen = 0; rd = '0;
        d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ram_re) re_n++;
            if (ram_we) begin we_n++; if (we_cyc == 0) we_cyc = c; end
            if (if_ack) saw_if = 1'b1;
            if (d_ack) begin lat = c; rd = d_rdata; err_seen = d_err; break; end
        end
        d_req = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(err_seen), 32'(err));
        check({tag, "_re_cycles"}, 32'(re_n), 32'(exp_re));
        check({tag, "_we_cycles"}, 32'(we_n), 32'(exp_we));
        if (exp_we != 0) check({tag, "_we_cycle"}, 32'(we_cyc), 32'(exp_we_cyc));
        check({tag, "_no_if_ack"}, 32'(saw_if), 32'd0);
        if (!we) check({tag, "_rdata"}, rd, err ? 32'h0 : ref_mem[idx]);
        if (we && !err) begin
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        if (!err) check({tag, "_ram_word"}, mem[idx], ref_mem[idx]);
        @(posedge clk); #1;
        check({tag, "_ack_pulse"}, 32'(d_ack), 32'd0);
    endtask

    task automatic fetch_txn(input string tag, input logic [AW-1:0] addr);
        int unsigned idx;
        logic        err, saw_d;
        int          lat, re_n, we_n;
        logic [31:0] rd;
        idx = 32'(addr) >> 2;
        err = (idx >= MW);
        lat = 0; re_n = 0; we_n = 0; saw_d = 0; rd = '0;
        if_req = 1'b1; if_addr = addr;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ram_re) re_n++;
            if (ram_we) we_n++;
            if (d_ack) saw_d = 1'b1;
            if (if_ack) begin lat = c; rd = if_rdata; break; end
        end
        if_req = 1'b0;
        check({tag, "_lat"}, 32'(lat), err ? 32'd1 : 32'd3);
        check({tag, "_rdata"}, rd, err ? 32'h0 : ref_mem[idx]);
        check({tag, "_re_cycles"}, 32'(re_n), err ? 32'd0 : 32'd1);
        check({tag, "_we_cycles"}, 32'(we_n), 32'd0);
        check({tag, "_no_d_ack"}, 32'(saw_d), 32'd0);
        @(posedge clk); #1;
        check({tag, "_ack_pulse"}, 32'(if_ack), 32'd0);
    endtask

    initial begin
        int          d_cyc, i_cyc;
        logic [31:0] d_rd, i_rd, old;
        logic        both;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        bk_we = 0; bk_idx = '0; bk_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_d_err", 32'(d_err), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);

        for (int i = 0; i < MW; i++) backdoor(i, $urandom);
        rst_n = 1'b1;
        @(posedge clk); #1;

        backdoor(4, 32'hDEADBEEF);
        fetch_txn("fetch_0x10", 16'h0010);

        data_txn("store_full", 1'b1, 4'hF, 16'h0020, 32'h12345678);
        data_txn("load_back", 1'b0, 4'h0, 16'h0020, 32'h0);
        check("load_back_const", ref_mem[8], 32'h12345678);

        backdoor(8, 32'hAABBCCDD);
        data_txn("rmw_be0010", 1'b1, 4'b0010, 16'h0020, 32'h00005500);
        check("rmw_ram8", mem[8], 32'hAABB55DD);

        data_txn("store_be0", 1'b1, 4'h0, 16'h0024, 32'hFFFFFFFF);
        data_txn("oor_load", 1'b0, 4'h0, 16'(MW * 4), 32'h0);
        data_txn("oor_store", 1'b1, 4'hF, 16'(MW * 4 + 8), 32'h55555555);
        fetch_txn("oor_fetch", 16'(MW * 4));
        data_txn("unaligned_load", 1'b0, 4'h0, 16'h0013, 32'h0);

        // Simultaneous requests: data port wins, fetch follows after returning to idle.
        d_cyc = 0; i_cyc = 0; d_rd = '0; i_rd = '0; both = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h000C; if_req = 1'b1; if_addr = 16'h0014;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (d_ack && if_ack) both = 1'b1;
            if (d_ack) begin d_cyc = c; d_rd = d_rdata; d_req = 1'b0; end
            if (if_ack) begin i_cyc = c; i_rd = if_rdata; if_req = 1'b0; end
            if (d_cyc != 0 && i_cyc != 0) break;
        end
        d_req = 1'b0; if_req = 1'b0;
        check("arb_d_lat", 32'(d_cyc), 32'd3);
        check("arb_if_lat", 32'(i_cyc), 32'd7);
        check("arb_d_rdata", d_rd, ref_mem[3]);
        check("arb_if_rdata", i_rd, ref_mem[5]);
        check("arb_no_overlap", 32'(both), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a full-word write.
        old = ref_mem[10];
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 16'h0028; d_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("rstw_we_before", 32'(ram_we), 32'd1);
        #2 rst_n = 1'b0; d_req = 1'b0;
        #1;
        check("rstw_we_dropped", 32'(ram_we), 32'd0);
        check("rstw_addr", 32'(ram_addr), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstw_ram_unchanged", mem[10], old);
        both = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (d_ack || if_ack || ram_we || ram_re) both = 1'b1;
        end
        check("rstw_idle_quiet", 32'(both), 32'd0);
        data_txn("rstw_load", 1'b0, 4'h0, 16'h0028, 32'h0);

        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            logic [3:0]  be;
            logic [AW-1:0] a;
            kind = $urandom_range(0, 5);
            a = 16'($urandom_range(0, MW * 4 + 31));
            case (kind)
                0:       be = 4'hF;
                1:       be = 4'h0;
                default: be = 4'($urandom_range(0, 15));
            endcase
            if (kind == 5) fetch_txn("rnd_fetch", a);
            else           data_txn("rnd_data", kind < 3 ? 1'b1 : 1'($urandom_range(0, 1)),
                                    be, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
